inv_nr_iter: RTL
================

INV_NR_ITER -- requirements
Module: inv_nr_iter

Interface
REQ-001 SHALL have parameter IPWRDLEN, default 16, meaning unsigned input width, integer format.
REQ-002 SHALL have parameter OPWRDLEN, default 24, meaning output mantissa width, format Q2.(OPWRDLEN-2).
REQ-003 SHALL have parameter LUTADDRW, default 6, meaning seed-ROM address width (2^LUTADDRW entries).
REQ-004 SHALL have parameter NITER, default 2, legal range 1..4, meaning Newton-Raphson iteration count.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on posedge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port x_in, input, IPWRDLEN bits: divisor operand.
REQ-008 SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: input handshake.
REQ-009 SHALL have port x_op, output, OPWRDLEN bits: normalised reciprocal mantissa.
REQ-010 SHALL have port exp_out, output, $clog2(IPWRDLEN+1) bits: exponent, where 1/x_in = x_op * 2^-exp_out.
REQ-011 SHALL have port div_zero, output, 1 bit: flags a zero operand.
REQ-012 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: output handshake.

Function
REQ-013 SHALL implement FSM states IDLE, NORM, SEED, ITER_A, ITER_B, DONE; in_ready=1 only in IDLE; one operation in flight.
REQ-014 SHALL capture x_in on the edge where in_valid&&in_ready, then go IDLE->NORM.
REQ-015 NORM SHALL count leading zeros lz, register d = x_in<<lz as Q0.IPWRDLEN in [0.5,1), and register exp_out = IPWRDLEN-lz; next state SEED.
REQ-016 If x_in==0, NORM SHALL go directly to DONE with div_zero=1, x_op=all ones, exp_out=0.
REQ-017 SEED SHALL register x = ROM[d bits IPWRDLEN-2 down to IPWRDLEN-1-LUTADDRW], clear iteration counter; next state ITER_A.
REQ-018 ROM entry i SHALL hold 1/(0.5+(i+0.5)*2^-(LUTADDRW+1)), Q2.(OPWRDLEN-2), rounded to nearest.
REQ-019 ITER_A SHALL register t = 2.0 - trunc(d*x) in Q2.(OPWRDLEN-2), modulo 2^OPWRDLEN; next state ITER_B.
REQ-020 ITER_B SHALL register x = trunc(x*t) to Q2.(OPWRDLEN-2), saturating to all ones when the integer bits of the product exceed 2 bits, and increment the counter; next state is DONE when counter==NITER, else ITER_A.
REQ-021 Latency SHALL be fixed: out_valid rises 3+2*NITER cycles after the accept edge (2 cycles for a zero operand).
REQ-022 DONE SHALL hold x_op, exp_out, div_zero and out_valid stable until out_ready=1, then return to IDLE on that edge.
REQ-023 in_valid SHALL be ignored outside IDLE; back-to-back operation SHALL accept the next input in the cycle after the DONE->IDLE handoff.
REQ-024 For non-zero x_in, the result SHALL be within +/-2 LSB of the exact value for NITER>=2.

Reset
REQ-025 rst_n=0 at a posedge SHALL force IDLE and clear x_op, exp_out, div_zero and out_valid to 0; in_ready SHALL be 1 the cycle after reset.
REQ-026 Reset asserted in any state SHALL abort the operation with no output produced.

Structure
REQ-027 Package inv_nr_pkg SHALL hold the FSM state enum, default width constants, and the ROM content function.
REQ-028 Sub-module inv_seed_rom SHALL hold the parametrised seed table (LUTADDRW in, OPWRDLEN out, combinational read).
REQ-029 Both multiplies SHALL share one OPWRDLEN x OPWRDLEN multiplier with the operand selected by state.

Verification
REQ-030 x_in=0x0001, NITER=2 -> x_op=0x800000 +/-2, exp_out=1, div_zero=0, out_valid at accept+7.
REQ-031 x_in=0xFFFF -> x_op=0x400040 +/-2, exp_out=16.
REQ-032 x_in=0x0000 -> div_zero=1, x_op=0xFFFFFF, exp_out=0, out_valid at accept+2.
REQ-033 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; a new in_valid is ignored.
REQ-034 rst_n pulsed low during ITER_A -> no out_valid; next op x_in=0x8000 -> x_op=0x800000 +/-2, exp_out=16.
REQ-035 Random sweep across NITER 1..4 against a real-number model within the REQ-024 bound.

Source files
------------

// File: rtl/inv_nr_pkg.sv
// Shared definitions for the Newton-Raphson reciprocal block.
//   state_t        : controller states
//   DEF_*          : default widths / iteration count
//   seed_value()   : rounded seed-table entry, 1/(0.5+(i+0.5)*2^-(L+1)) in Q2.(O-2)
package inv_nr_pkg;

    localparam int DEF_IPWRDLEN = 16;
    localparam int DEF_OPWRDLEN = 24;
    localparam int DEF_LUTADDRW = 6;
    localparam int DEF_NITER    = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NORM   = 3'd1,
        SEED   = 3'd2,
        ITER_A = 3'd3,
        ITER_B = 3'd4,
        DONE   = 3'd5
    } state_t;

    // 0.5+(i+0.5)/2^(L+1) = (2^(L+1)+2i+1)/2^(L+2), so the scaled reciprocal is
    // 2^(O-2) * 2^(L+2) / (2^(L+1)+2i+1), rounded to nearest.
    function automatic logic [63:0] seed_value(input int idx, input int lutaddrw,
                                               input int opwrdlen);
        logic [63:0] num;
        logic [63:0] den;
        num = 64'd1 << (opwrdlen + lutaddrw);
        den = (64'd1 << (lutaddrw + 1)) + 64'(2 * idx + 1);
        return (num + (den >> 1)) / den;
    endfunction

endpackage

// File: rtl/inv_seed_rom.sv
// Seed table for the reciprocal iteration: entry i is the reciprocal of the
// midpoint of mantissa bucket i, Q2.(OPWRDLEN-2). Combinational read.
//   addr : bucket index (mantissa bits just below the leading one)
//   data : seed reciprocal
module inv_seed_rom
    import inv_nr_pkg::*;
#(
    parameter int LUTADDRW = DEF_LUTADDRW,
    parameter int OPWRDLEN = DEF_OPWRDLEN
) (
    input  logic [LUTADDRW-1:0] addr,
    output logic [OPWRDLEN-1:0] data
);

    logic [OPWRDLEN-1:0] rom_s [2**LUTADDRW];

    for (genvar g = 0; g < 2**LUTADDRW; g++) begin : g_rom
        assign rom_s[g] = OPWRDLEN'(seed_value(g, LUTADDRW, OPWRDLEN));
    end

    assign data = rom_s[addr];

endmodule

// File: rtl/inv_nr_iter.sv
// Iterative reciprocal: 1/x_in = x_op * 2^-exp_out.
// The operand is normalised to d in [0.5,1), seeded from a table, then refined
// with NITER Newton-Raphson steps x <- x*(2 - d*x) using one shared multiplier.
//   clk, rst_n            : clock, synchronous active-low reset
//   x_in/in_valid/in_ready: operand handshake (in_ready only while idle)
//   x_op                  : Q2.(OPWRDLEN-2) reciprocal mantissa
//   exp_out               : exponent
//   div_zero              : operand was zero (x_op all ones, exp_out 0)
//   out_valid/out_ready   : result handshake, result held until taken
module inv_nr_iter
    import inv_nr_pkg::*;
#(
    parameter int IPWRDLEN = DEF_IPWRDLEN,
    parameter int OPWRDLEN = DEF_OPWRDLEN,
    parameter int LUTADDRW = DEF_LUTADDRW,
    parameter int NITER    = DEF_NITER
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [IPWRDLEN-1:0]               x_in,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [OPWRDLEN-1:0]               x_op,
    output logic [$clog2(IPWRDLEN+1)-1:0]     exp_out,
    output logic                              div_zero,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int EXPW   = $clog2(IPWRDLEN + 1);
    // d is Q0.IPWRDLEN; moving it onto the Q2.(OPWRDLEN-2) grid is a left shift.
    localparam int DSHIFT = OPWRDLEN - 2 - IPWRDLEN;
    localparam logic [OPWRDLEN-1:0] TWO_C  = {2'b10, {(OPWRDLEN-2){1'b0}}};
    localparam logic [OPWRDLEN-1:0] ONES_C = {OPWRDLEN{1'b1}};

    state_t                state_r;
    logic [IPWRDLEN-1:0]   xin_r;
    logic [IPWRDLEN-1:0]   d_r;
    logic [EXPW-1:0]       exp_r;
    logic                  zero_r;
    logic [OPWRDLEN-1:0]   x_r;
    logic [OPWRDLEN-1:0]   t_r;
    logic [2:0]            cnt_r;

    logic [EXPW-1:0]       lz_s;
    logic [OPWRDLEN-1:0]   rom_data_s;
    logic [OPWRDLEN-1:0]   d_ext_s;
    logic [OPWRDLEN-1:0]   mul_a_s;
    logic [OPWRDLEN-1:0]   mul_b_s;
    logic [2*OPWRDLEN-1:0] prod_s;
    logic [1:0]            prod_hi_s;
    logic [OPWRDLEN-1:0]   prod_trunc_s;
    logic [OPWRDLEN-3:0]   prod_unused_s;
    logic [2:0]            cnt_next_s;

    inv_seed_rom #(
        .LUTADDRW (LUTADDRW),
        .OPWRDLEN (OPWRDLEN)
    ) u_rom (
        .addr (d_r[IPWRDLEN-2 -: LUTADDRW]),
        .data (rom_data_s)
    );

    // Leading-zero count: the highest set bit wins because the scan runs upward.
    always_comb begin
        lz_s = {EXPW{1'b0}};
        for (int i = 0; i < IPWRDLEN; i++) begin
            if (xin_r[i]) begin
                lz_s = EXPW'(IPWRDLEN - 1 - i);
            end else begin
                lz_s = lz_s;
            end
        end
    end

    assign d_ext_s = OPWRDLEN'(d_r) << DSHIFT;

    // Shared multiplier operands: d*x during ITER_A, x*t otherwise.
    always_comb begin
        if (state_r == ITER_A) begin
            mul_a_s = d_ext_s;
            mul_b_s = x_r;
        end else begin
            mul_a_s = x_r;
            mul_b_s = t_r;
        end
    end

    // Q4.(2*OPWRDLEN-4) product; the middle slice is the truncated Q2 value.
    assign prod_s = {{OPWRDLEN{1'b0}}, mul_a_s} * {{OPWRDLEN{1'b0}}, mul_b_s};
    assign {prod_hi_s, prod_trunc_s, prod_unused_s} = prod_s;
    assign cnt_next_s = cnt_r + 3'd1;

    // Controller and datapath registers, including all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x_op      <= {OPWRDLEN{1'b0}};
            exp_out   <= {EXPW{1'b0}};
            div_zero  <= 1'b0;
            xin_r     <= {IPWRDLEN{1'b0}};
            d_r       <= {IPWRDLEN{1'b0}};
            exp_r     <= {EXPW{1'b0}};
            zero_r    <= 1'b0;
            x_r       <= {OPWRDLEN{1'b0}};
            t_r       <= {OPWRDLEN{1'b0}};
            cnt_r     <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        xin_r    <= x_in;
                        in_ready <= 1'b0;
                        state_r  <= NORM;
                    end
                end
                NORM: begin
                    if (xin_r == {IPWRDLEN{1'b0}}) begin
                        zero_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        zero_r  <= 1'b0;
                        d_r     <= xin_r << lz_s;
                        exp_r   <= EXPW'(IPWRDLEN) - lz_s;
                        state_r <= SEED;
                    end
                end
                SEED: begin
                    x_r     <= rom_data_s;
                    cnt_r   <= 3'd0;
                    state_r <= ITER_A;
                end
                ITER_A: begin
                    // Wraps modulo 2^OPWRDLEN; d*x stays well below 2.0 here.
                    t_r     <= TWO_C - prod_trunc_s;
                    state_r <= ITER_B;
                end
                ITER_B: begin
                    x_r   <= (prod_hi_s != 2'b00) ? ONES_C : prod_trunc_s;
                    cnt_r <= cnt_next_s;
                    if (cnt_next_s == 3'(NITER)) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= ITER_A;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; then wait for the sink.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        if (zero_r) begin
                            x_op     <= ONES_C;
                            exp_out  <= {EXPW{1'b0}};
                            div_zero <= 1'b1;
                        end else begin
                            x_op     <= x_r;
                            exp_out  <= exp_r;
                            div_zero <= 1'b0;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
